hockey_disp_scan: RTL and testbench
===================================

# hockey_disp_scan

Downstream display stage for the hockey game core: consumes the puck position (`X_COORD`, `Y_COORD`) and drives a 4-digit multiplexed common-anode seven-segment display. Coordinates are sampled once per scan frame, so the display never tears mid-frame. Digits 1/0 show the current X/Y; digits 3/2 show the previous distinct position (trail), giving the players the puck direction.

## Interface
- `DIV_W`, 16: prescaler width; one digit slot lasts 2^DIV_W clocks.
- `MAX_COORD`, 4: largest legal coordinate; larger values render as a dash.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `X_COORD` in 3: puck X from the game core.
- `Y_COORD` in 3: puck Y from the game core.
- `AN` out 4: digit enables, active-low; bit i = digit i.
- `SEG` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `DP` out 1: decimal point, active-low.
- `FRAME` out 1: one-cycle pulse per new frame sample.

## Operation
- Prescaler `cnt` (DIV_W bits) increments every clock, wraps freely; `tick` = (`cnt` == all ones).
- Digit index `dig` (2 bits) increments on `tick`, wraps 3->0.
- Frame boundary = `tick` while `dig`==3. On it: `cur_x/cur_y` <= `X_COORD/Y_COORD`. If the sampled pair differs from `cur_x/cur_y`, `prev_x/prev_y` <= old `cur_x/cur_y` and `prev_vld` <= 1. An identical sample leaves prev unchanged.
- Digit map: dig0 = `cur_y`, dig1 = `cur_x`, dig2 = `prev_y`, dig3 = `prev_x`.
- DP lit (0) only in the dig1 slot (X.Y separator).
- Glyphs (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001. Values 5..7 and values > `MAX_COORD` produce a dash (0111111). Blank = 1111111.
- Digits 2/3 are blank while `prev_vld`==0. Their `AN` bit still asserts in its slot, keeping the scan duty constant.
- Exactly one `AN` bit is low at any time after the first clock out of reset.
- State: `cnt`, `dig`, `cur_x/y`, `prev_x/y`, `prev_vld`, registered outputs. No other FSM.

## Timing
- Reset (rst=0, async): `cnt`=0, `dig`=0, cur/prev=0, `prev_vld`=0. `AN`=1111, `SEG`=1111111, `DP`=1, `FRAME`=0.
- All outputs are registered: `AN`/`SEG`/`DP` reflect the `dig` and registers of the previous clock (1-cycle latency).
- First clock edge after reset release: `AN`=1110, `SEG`=glyph(0)=1000000.
- `FRAME` is high for exactly one clock, the cycle after the frame-boundary edge.
- Coordinate change to display: captured at the next frame boundary, worst case 4*2^DIV_W clocks, plus 1 clock to the outputs.
- Input changes between frame boundaries are ignored. Only the value present on the boundary edge counts.
- Reset asserted mid-frame: immediate return to reset values; trail history is lost.
- `X_COORD`/`Y_COORD` are synchronous to `clk` (from the game core), so no synchronizer is needed.

## Configuration
- `HOCKEY_TRAIL_EN` defined: prev registers, `prev_vld` and the digit 2/3 trail rendering are present as described.
- Undefined: no prev registers; digits 2/3 are always blank but still scanned (`AN` cycles through all four); digits 0/1, `DP` and `FRAME` are unchanged.

## Test plan
All scenarios use DIV_W=2: slot = 4 clocks, frame = 16 clocks.
- Reset then release with X=0, Y=0: outputs all-off during reset. `AN` steps 1110,1101,1011,0111 every 4 clocks; dig0/dig1 show 1000000; dig1 has `DP`=0; digits 2/3 show 1111111.
- Drive X=2, Y=4 before a frame boundary: one-cycle `FRAME` pulse. Next frame shows dig1=0100100, dig0=0011001; with `HOCKEY_TRAIL_EN`, dig3/dig2 show 0 (previous 0,0).
- Change X=3 mid-frame, then back to 2 before the boundary: no visible change and prev is not updated.
- Hold X=2, Y=4 for 5 frames: prev remains 0,0 and `FRAME` pulses 5 times, 16 clocks apart.
- Drive X=6, Y=5: dig1 and dig0 show a dash (0111111); prev = 2,4.
- Assert rst mid-slot: `AN`=1111 on the same cycle (asynchronous). After release, digits 2/3 are blank until the next coordinate change.

Source files
------------

// File: rtl/hockey_disp_scan.sv
// hockey_disp_scan: display stage for the hockey game core.
//
// Samples the puck position once per scan frame and drives a 4-digit multiplexed
// common-anode seven-segment display. Digits 1/0 show the current X/Y; digits 3/2
// show the previous distinct position (trail) so players can see puck direction.
//
// Optional feature macro: HOCKEY_TRAIL_EN
//   defined   : trail registers present, digits 3/2 show the previous position
//   undefined : no trail registers, digits 3/2 always blank (still scanned)
//
// Parameters:
//   DIV_W     - prescaler width; one digit slot lasts 2^DIV_W clocks
//   MAX_COORD - largest legal coordinate; larger values render as a dash
//
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous reset, active-low
//   X_COORD in  puck X (synchronous to clk)
//   Y_COORD in  puck Y (synchronous to clk)
//   AN      out digit enables, active-low, bit i = digit i
//   SEG     out segments {g,f,e,d,c,b,a}, active-low
//   DP      out decimal point, active-low (lit in the digit 1 slot only)
//   FRAME   out one-cycle pulse after each frame sample
module hockey_disp_scan #(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned MAX_COORD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] X_COORD,
    input  logic [2:0] Y_COORD,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       FRAME
);

    localparam logic [6:0]       SegBlank = 7'b1111111;
    localparam logic [6:0]       SegDash  = 7'b0111111;
    localparam logic [DIV_W-1:0] CntOne   = DIV_W'(1);

    // Active-low glyph for one coordinate; anything outside 0..MAX_COORD is a dash.
    function automatic logic [6:0] glyph(input logic [2:0] v);
        logic [6:0] g;
        g = SegDash;
        if (32'(v) <= MAX_COORD) begin
            case (v)
                3'd0:    g = 7'b1000000;
                3'd1:    g = 7'b1111001;
                3'd2:    g = 7'b0100100;
                3'd3:    g = 7'b0110000;
                3'd4:    g = 7'b0011001;
                default: g = SegDash;
            endcase
        end
        return g;
    endfunction

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic [2:0]       cur_x_q, cur_x_d;
    logic [2:0]       cur_y_q, cur_y_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_q, frame_d;

    logic tick;
    logic frame_b;

    // Glyphs for the trail digits; blank when the trail is absent or not yet valid.
    logic [6:0] trail_y_seg;
    logic [6:0] trail_x_seg;

    assign tick    = &cnt_q;
    assign frame_b = tick && (dig_q == 2'd3);

`ifdef HOCKEY_TRAIL_EN
    logic [2:0] prev_x_q, prev_x_d;
    logic [2:0] prev_y_q, prev_y_d;
    logic       prev_vld_q, prev_vld_d;

    // Only a sample that differs from the current position pushes it into the trail,
    // so a stationary puck keeps its last direction visible.
    always_comb begin
        prev_x_d   = prev_x_q;
        prev_y_d   = prev_y_q;
        prev_vld_d = prev_vld_q;
        if (frame_b && ({X_COORD, Y_COORD} != {cur_x_q, cur_y_q})) begin
            prev_x_d   = cur_x_q;
            prev_y_d   = cur_y_q;
            prev_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_x_q   <= 3'd0;
            prev_y_q   <= 3'd0;
            prev_vld_q <= 1'b0;
        end else begin
            prev_x_q   <= prev_x_d;
            prev_y_q   <= prev_y_d;
            prev_vld_q <= prev_vld_d;
        end
    end

    assign trail_y_seg = prev_vld_q ? glyph(prev_y_q) : SegBlank;
    assign trail_x_seg = prev_vld_q ? glyph(prev_x_q) : SegBlank;
`else
    assign trail_y_seg = SegBlank;
    assign trail_x_seg = SegBlank;
`endif

    always_comb begin
        cnt_d   = cnt_q + CntOne;
        dig_d   = tick ? dig_q + 2'd1 : dig_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (frame_b) begin
            cur_x_d = X_COORD;
            cur_y_d = Y_COORD;
        end

        // Outputs are built from the pre-edge slot and registers: one cycle of latency.
        an_d    = ~(4'b0001 << dig_q);
        dp_d    = (dig_q != 2'd1);
        frame_d = frame_b;
        case (dig_q)
            2'd0:    seg_d = glyph(cur_y_q);
            2'd1:    seg_d = glyph(cur_x_q);
            2'd2:    seg_d = trail_y_seg;
            default: seg_d = trail_x_seg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            dig_q   <= 2'd0;
            cur_x_q <= 3'd0;
            cur_y_q <= 3'd0;
            an_q    <= 4'b1111;
            seg_q   <= SegBlank;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    assign AN    = an_q;
    assign SEG   = seg_q;
    assign DP    = dp_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_hockey_disp_scan.sv
// Directed self-checking bench for hockey_disp_scan with DIV_W=2 (slot = 4 clocks,
// frame = 16 clocks). Inputs are driven and outputs sampled on the falling edge.
module tb_hockey_disp_scan;

    localparam logic [6:0] G0    = 7'b1000000;
    localparam logic [6:0] G2    = 7'b0100100;
    localparam logic [6:0] G4    = 7'b0011001;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

`ifdef HOCKEY_TRAIL_EN
    localparam bit TRAIL = 1'b1;
`else
    localparam bit TRAIL = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] x;
    logic [2:0] y;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int frame_seen = 0;

    hockey_disp_scan #(
        .DIV_W     (2),
        .MAX_COORD (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .X_COORD (x),
        .Y_COORD (y),
        .AN      (an),
        .SEG     (seg),
        .DP      (dp),
        .FRAME   (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Trail digits are blank in the build without the trail feature.
    function automatic logic [6:0] tr(input logic [6:0] g);
        return TRAIL ? g : BLANK;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        x   = 3'd0;
        y   = 3'd0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (an !== 4'b1111) $display("FAIL reset_an got %b exp 1111", an);
        else pass_cnt++;
        total_cnt++;
        if (seg !== BLANK) $display("FAIL reset_seg got %b exp %b", seg, BLANK);
        else pass_cnt++;
        total_cnt++;
        if (dp !== 1'b1) $display("FAIL reset_dp got %b exp 1", dp);
        else pass_cnt++;
        total_cnt++;
        if (frame !== 1'b0) $display("FAIL reset_frame got %b exp 0", frame);
        else pass_cnt++;
        rst = 1'b1;
    endtask

    // Scans one full frame starting right after a frame boundary (or reset release),
    // checking every cycle. The last edge of the frame is the next boundary, so FRAME
    // must be high only after it. Optional glitch on X mid-frame that is undone
    // before the boundary.
    task automatic test_scan(input string nm, input logic [6:0] g0, input logic [6:0] g1,
                             input logic [6:0] g2, input logic [6:0] g3,
                             input bit glitch_en, input logic [2:0] gx);
        logic [2:0] saved_x;
        logic [6:0] exp_seg;
        logic [3:0] exp_an;
        int         slot;
        saved_x = x;
        for (int i = 0; i < 16; i++) begin
            if (glitch_en && i == 4) x = gx;
            if (glitch_en && i == 10) x = saved_x;
            @(posedge clk);
            @(negedge clk);
            slot = i / 4;
            exp_an = 4'b1111;
            exp_an[slot] = 1'b0;
            case (slot)
                0:       exp_seg = g0;
                1:       exp_seg = g1;
                2:       exp_seg = g2;
                default: exp_seg = g3;
            endcase
            if (frame === 1'b1) frame_seen++;
            total_cnt++;
            if (an !== exp_an) $display("FAIL %s_an cyc %0d got %b exp %b", nm, i, an, exp_an);
            else pass_cnt++;
            total_cnt++;
            if (seg !== exp_seg)
                $display("FAIL %s_seg cyc %0d got %b exp %b", nm, i, seg, exp_seg);
            else pass_cnt++;
            total_cnt++;
            if (dp !== (slot != 1))
                $display("FAIL %s_dp cyc %0d got %b exp %b", nm, i, dp, slot != 1);
            else pass_cnt++;
            total_cnt++;
            if (frame !== (i == 15))
                $display("FAIL %s_frame cyc %0d got %b exp %b", nm, i, frame, i == 15);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        int start;
        start = frame_seen;
        for (int f = 0; f < 5; f++) test_scan("hold", G4, G2, tr(G0), tr(G0), 1'b0, 3'd0);
        total_cnt++;
        if (frame_seen - start !== 5)
            $display("FAIL hold_pulses got %0d exp 5", frame_seen - start);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        total_cnt++;
        if (an !== 4'b1101) $display("FAIL midrst_pre_an got %b exp 1101", an);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if (an !== 4'b1111) $display("FAIL midrst_an got %b exp 1111", an);
        else pass_cnt++;
        total_cnt++;
        if (seg !== BLANK) $display("FAIL midrst_seg got %b exp %b", seg, BLANK);
        else pass_cnt++;
        total_cnt++;
        if (dp !== 1'b1) $display("FAIL midrst_dp got %b exp 1", dp);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_scan("boot", G0, G0, BLANK, BLANK, 1'b0, 3'd0);
        x = 3'd2;
        y = 3'd4;
        test_scan("pre_capture", G0, G0, BLANK, BLANK, 1'b0, 3'd0);
        test_scan("new_coord", G4, G2, tr(G0), tr(G0), 1'b0, 3'd0);
        test_scan("glitch", G4, G2, tr(G0), tr(G0), 1'b1, 3'd3);
        test_scan("post_glitch", G4, G2, tr(G0), tr(G0), 1'b0, 3'd0);
        test_hold();
        x = 3'd6;
        y = 3'd5;
        test_scan("pre_dash", G4, G2, tr(G0), tr(G0), 1'b0, 3'd0);
        test_scan("dash", DASH, DASH, tr(G4), tr(G2), 1'b0, 3'd0);
        test_reset_mid();
        test_scan("post_rst", G0, G0, BLANK, BLANK, 1'b0, 3'd0);
        test_scan("trail_back", DASH, DASH, tr(G0), tr(G0), 1'b0, 3'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
